// File: rtl/counter_clear_up_if.sv
// -----------------------------------------------------------------------------
// counter_clear_up_if
//
// Purpose:
//   Groups the per-cycle control inputs and the count output of a
//   counter_clear_up instance into one bundle.
//
// Parameters:
//   max_val_p : largest value the attached counter represents. The count
//               width is derived from it exactly as the counter derives it.
//
// Signals:
//   clear_i : synchronous clear request (level-sampled every cycle)
//   up_i    : increment request (level-sampled every cycle)
//   count_o : current count, driven from the counter's state register
//
// Modports:
//   master : the side that requests clears/increments and reads the count
//   slave  : the counter itself
// -----------------------------------------------------------------------------
interface counter_clear_up_if #(
    parameter int max_val_p = 255
);

    // A degenerate max_val_p still gets one bit so the bundle stays legal.
    localparam int width_lp = (max_val_p < 1) ? 1 : $clog2(max_val_p + 1);

    logic                clear_i;
    logic                up_i;
    logic [width_lp-1:0] count_o;

    modport master (
        output clear_i,
        output up_i,
        input  count_o
    );

    modport slave (
        input  clear_i,
        input  up_i,
        output count_o
    );

endinterface

// File: rtl/counter_clear_up.sv
// -----------------------------------------------------------------------------
// counter_clear_up
//
// Purpose:
//   Synchronous up-counter with synchronous clear, used to count retired
//   instructions. The count feeds an instruction-cap comparator, so it is
//   exported straight from the state register with no combinational path
//   from the inputs.
//
// Parameters:
//   max_val_p                  : largest representable count (>= 1); sets width
//   init_val_p                 : value loaded on reset (0 .. max_val_p)
//   disable_overflow_warning_p : 1 silences the simulation overflow message
//
// Ports:
//   clk_i   : clock, all state changes on the rising edge
//   reset_i : synchronous active-high reset (may have a freeze OR'd in)
//   ctr     : slave side of counter_clear_up_if (clear_i, up_i, count_o)
//
// Per-edge priority: reset -> clear (with optional same-cycle increment)
//   -> increment (wrapping from max_val_p to 0) -> hold.
// -----------------------------------------------------------------------------
module counter_clear_up #(
    parameter int max_val_p                  = 255,
    parameter int init_val_p                 = 0,
    parameter int disable_overflow_warning_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    counter_clear_up_if.slave  ctr
);

    localparam int width_lp = (max_val_p < 1) ? 1 : $clog2(max_val_p + 1);

    localparam logic [width_lp-1:0] max_lp  = width_lp'(max_val_p);
    localparam logic [width_lp-1:0] init_lp = width_lp'(init_val_p);
    localparam logic [width_lp-1:0] one_lp  = width_lp'(1);

    // Illegal parameter combinations are caught at elaboration.
    if (max_val_p < 1) begin : g_bad_max
        $error("counter_clear_up: max_val_p (%0d) must be at least 1", max_val_p);
    end

    if ((init_val_p < 0) || (init_val_p > max_val_p)) begin : g_bad_init
        $error("counter_clear_up: init_val_p (%0d) must lie in 0..max_val_p (%0d)",
               init_val_p, max_val_p);
    end

    logic [width_lp-1:0] count_d;
    logic [width_lp-1:0] count_q;
    logic                at_max;

    assign at_max = (count_q == max_lp);

    // Next-state selection. Clear together with up lands on 1 because both
    // requests take effect in the same cycle. Wrapping is explicit rather
    // than relying on natural overflow, since max_val_p need not be 2^n-1.
    always_comb begin
        count_d = count_q;
        if (reset_i) begin
            count_d = init_lp;
        end else if (ctr.clear_i) begin
            count_d = ctr.up_i ? one_lp : '0;
        end else if (ctr.up_i) begin
            count_d = at_max ? '0 : (count_q + one_lp);
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign ctr.count_o = count_q;

    // Simulation-only notice when the counter wraps; it does not alter state.
    if (disable_overflow_warning_p == 0) begin : g_overflow_warn
        always_ff @(posedge clk_i) begin
            if (!reset_i && !ctr.clear_i && ctr.up_i && at_max) begin
                $warning("counter_clear_up: counter overflow in %m (wrapped past %0d)",
                         max_val_p);
            end
        end
    end

endmodule

// File: tb/tb_counter_clear_up.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_counter_clear_up
//
// Six counter instances with different parameter sets share one clock and one
// reset; each has its own clear/up drive. A behavioural model computes every
// expected count using modular arithmetic on the parameter values.
//   0: max 15,      init 3
//   1: max 7,       init 0            (overflow message enabled)
//   2: max 7,       init 0            (overflow message disabled)
//   3: max 1,       init 0            (1-bit counter)
//   4: max 2^30,    init 2^30-1       (31-bit counter, wraps near the top)
//   5: max 255,     init 0            (mid-count reset from 100)
// -----------------------------------------------------------------------------
module tb_counter_clear_up;

    localparam int numDut = 6;

    localparam int max0 = 15;
    localparam int max1 = 7;
    localparam int max2 = 7;
    localparam int max3 = 1;
    localparam int max4 = 1 << 30;
    localparam int max5 = 255;

    localparam int init0 = 3;
    localparam int init1 = 0;
    localparam int init2 = 0;
    localparam int init3 = 0;
    localparam int init4 = (1 << 30) - 1;
    localparam int init5 = 0;

    logic clk = 1'b0;
    logic reset_i;

    int checks   = 0;
    int failures = 0;

    longint maxVal  [numDut];
    longint initVal [numDut];
    longint model   [numDut];

    always #5 clk = ~clk;

    counter_clear_up_if #(.max_val_p(max0)) if0 ();
    counter_clear_up_if #(.max_val_p(max1)) if1 ();
    counter_clear_up_if #(.max_val_p(max2)) if2 ();
    counter_clear_up_if #(.max_val_p(max3)) if3 ();
    counter_clear_up_if #(.max_val_p(max4)) if4 ();
    counter_clear_up_if #(.max_val_p(max5)) if5 ();

    counter_clear_up #(.max_val_p(max0), .init_val_p(init0), .disable_overflow_warning_p(0))
        dut0 (.clk_i(clk), .reset_i(reset_i), .ctr(if0));
    counter_clear_up #(.max_val_p(max1), .init_val_p(init1), .disable_overflow_warning_p(0))
        dut1 (.clk_i(clk), .reset_i(reset_i), .ctr(if1));
    counter_clear_up #(.max_val_p(max2), .init_val_p(init2), .disable_overflow_warning_p(1))
        dut2 (.clk_i(clk), .reset_i(reset_i), .ctr(if2));
    counter_clear_up #(.max_val_p(max3), .init_val_p(init3), .disable_overflow_warning_p(0))
        dut3 (.clk_i(clk), .reset_i(reset_i), .ctr(if3));
    counter_clear_up #(.max_val_p(max4), .init_val_p(init4), .disable_overflow_warning_p(0))
        dut4 (.clk_i(clk), .reset_i(reset_i), .ctr(if4));
    counter_clear_up #(.max_val_p(max5), .init_val_p(init5), .disable_overflow_warning_p(0))
        dut5 (.clk_i(clk), .reset_i(reset_i), .ctr(if5));

    // Reference rule set: reset wins, then clear (landing on 0 or 1 depending
    // on up), then increment modulo max+1, otherwise hold.
    function automatic longint nextVal(input longint cur, input longint mx,
                                       input longint init, input bit rst,
                                       input bit clr, input bit up);
        if (rst) return init;
        if (clr) return up ? 64'sd1 : 64'sd0;
        if (up)  return (cur + 1) % (mx + 1);
        return cur;
    endfunction

    // Drive one cycle of inputs (called just after a falling edge), let the
    // rising edge happen, advance the model, and return on the next falling
    // edge so outputs are sampled away from the active edge.
    task automatic applyStimulus(input logic rst, input logic [numDut-1:0] clr,
                                 input logic [numDut-1:0] up);
        reset_i    = rst;
        if0.clear_i = clr[0]; if0.up_i = up[0];
        if1.clear_i = clr[1]; if1.up_i = up[1];
        if2.clear_i = clr[2]; if2.up_i = up[2];
        if3.clear_i = clr[3]; if3.up_i = up[3];
        if4.clear_i = clr[4]; if4.up_i = up[4];
        if5.clear_i = clr[5]; if5.up_i = up[5];
        @(posedge clk);
        for (int i = 0; i < numDut; i++) begin
            model[i] = nextVal(model[i], maxVal[i], initVal[i], rst, clr[i], up[i]);
        end
        @(negedge clk);
    endtask

    // Compare every instance's count against the model.
    task automatic checkOutput(input string tag);
        logic [63:0] obs [numDut];
        logic [63:0] exp;
        obs[0] = 64'(if0.count_o);
        obs[1] = 64'(if1.count_o);
        obs[2] = 64'(if2.count_o);
        obs[3] = 64'(if3.count_o);
        obs[4] = 64'(if4.count_o);
        obs[5] = 64'(if5.count_o);
        for (int i = 0; i < numDut; i++) begin
            exp = 64'(model[i]);
            checks++;
            assert (obs[i] === exp) else begin
                failures++;
                $error("[TB] FAIL %s dut%0d observed=%0d expected=%0d", tag, i, obs[i], exp);
            end
        end
    endtask

    // Cycle-count watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [numDut-1:0] rClr;
        logic [numDut-1:0] rUp;
        logic              rRst;

        maxVal  = '{max0, max1, max2, max3, max4, max5};
        initVal = '{init0, init1, init2, init3, init4, init5};
        for (int i = 0; i < numDut; i++) model[i] = 0;

        reset_i = 1'b0;
        if0.clear_i = 1'b0; if0.up_i = 1'b0;
        if1.clear_i = 1'b0; if1.up_i = 1'b0;
        if2.clear_i = 1'b0; if2.up_i = 1'b0;
        if3.clear_i = 1'b0; if3.up_i = 1'b0;
        if4.clear_i = 1'b0; if4.up_i = 1'b0;
        if5.clear_i = 1'b0; if5.up_i = 1'b0;
        @(negedge clk);

        // Reset held two cycles with up asserted: reset must win.
        applyStimulus(1'b1, '0, '1); checkOutput("reset_cycle1");
        applyStimulus(1'b1, '0, '1); checkOutput("reset_cycle2");

        // Count four cycles after release (dut0: 4,5,6,7; dut4 crosses its wrap).
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, '0, '1); checkOutput("count_after_reset");
        end

        // Increment/hold pattern 1,0,1,1,0.
        applyStimulus(1'b0, '0, '1); checkOutput("pattern_up1");
        applyStimulus(1'b0, '0, '0); checkOutput("pattern_hold1");
        applyStimulus(1'b0, '0, '1); checkOutput("pattern_up2");
        applyStimulus(1'b0, '0, '1); checkOutput("pattern_up3");
        applyStimulus(1'b0, '0, '0); checkOutput("pattern_hold2");

        // Clear alone, count up a bit, clear with up, then reset with both.
        applyStimulus(1'b0, '1, '0); checkOutput("clear_only");
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, '0, '1);
        checkOutput("count_before_clear_up");
        applyStimulus(1'b0, '1, '1); checkOutput("clear_and_up");
        applyStimulus(1'b1, '1, '1); checkOutput("reset_over_clear_up");

        // Walk dut1/dut2 across their wrap point (7 -> 0) and beyond.
        applyStimulus(1'b0, '1, '0); checkOutput("clear_before_wrap");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, '0, '1); checkOutput("wrap_walk");
        end

        // Randomized traffic, occasional reset, sparse clears.
        for (int k = 0; k < 200; k++) begin
            rRst = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < numDut; i++) begin
                rClr[i] = ($urandom_range(0, 7) == 0);
                rUp[i]  = ($urandom_range(0, 3) != 0);
            end
            applyStimulus(rRst, rClr, rUp); checkOutput("random");
        end

        // Mid-count reset on dut5 from 100 with up held high.
        applyStimulus(1'b0, '1, '0);
        for (int k = 0; k < 100; k++) applyStimulus(1'b0, '0, '1);
        checkOutput("reach_100");
        applyStimulus(1'b1, '0, '1); checkOutput("mid_count_reset");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, '0, '1); checkOutput("resume_after_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
